multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Multi-cycle multiply/divide unit beside the execute stage of the 5-stage pipeline.
- Accepts R-type mul/div instructions from the D/X latch and runs iterative 32-bit signed shift-add multiply or restoring divide.
- Produces the writeback request, the exception flag, and the multOngoing / in-flight-instruction pair that the hazard stall logic compares against decode-stage rs/rt.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; clears all state
- dx_insn  input  32  instruction in D/X: opcode [31:27], rd [26:22], ALU op [6:2]
- dx_kill  input  1  D/X instruction squashed (branch/jump flush); blocks acceptance
- operandA  input  32  bypassed rs value for dx_insn
- operandB  input  32  bypassed rt value for dx_insn
- multOngoing  output  1  operation in flight (RUN or FIX)
- inM  output  32  latched instruction of the in-flight operation; 0 when IDLE
- md_stall  output  1  structural stall: new mul/div in D/X while unit is occupied
- result  output  32  final result, valid only when result_valid=1
- result_valid  output  1  one-cycle writeback request
- wb_rd  output  5  destination register (= inM[26:22]) during result_valid
- exception  output  1  div-by-zero or mul overflow; qualified by result_valid

Behaviour:
- Decode: is_mul = opcode 00000 & ALU op 00110; is_div = opcode 00000 & ALU op 00111. Other ALU ops never start the unit.
- start = (is_mul | is_div) & ~dx_kill & state in {IDLE, DONE}.
- States: IDLE, RUN, FIX, DONE.
  - IDLE: start -> RUN. Latch dx_insn into inM, store |operandA| and |operandB| magnitudes plus result sign (mul: signA^signB; div: signA^signB for quotient). Clear counter to 0.
  - Divide with operandB==0 goes IDLE -> DONE directly: result=0, exception=1.
  - RUN: one iteration per cycle. Counter increments 0..WIDTH-1; at count WIDTH-1 -> FIX.
  - Multiply uses a 64-bit unsigned product register. Divide uses a 32-bit remainder and 32-bit quotient, restoring algorithm.
  - FIX: apply two's-complement negation if the sign bit is set. Mul overflow = signed 64-bit product does not fit 32 bits (upper 33 bits not all equal). FIX -> DONE.
  - Divide overflow: -2^31 / -1 gives result 0x80000000 with exception=1.
  - DONE: result_valid=1 for exactly this cycle, with wb_rd=inM[26:22], result, and exception. Next state: start ? RUN (back-to-back accept, inM reloaded) : IDLE.
- Latency, normal op: accept edge at cycle T. RUN occupies T+1..T+32, FIX is T+33, DONE is T+34.
- Latency, div-by-zero: DONE at T+1.
- multOngoing = 1 in RUN and FIX; 0 in IDLE and DONE.
  - In DONE the register file writes on the edge ending DONE, and write-before-read covers a released consumer.
- inM holds its value through RUN, FIX and DONE. It returns to 0 on entering IDLE.
- md_stall = (is_mul | is_div) & ~dx_kill & state in {RUN, FIX}. The pipeline holds F/D and D/X while md_stall=1, and the unit does not accept.
- dx_kill has priority over start. A killed mul/div is never latched and never raises md_stall.
- Signed operation, truncating division: remainder is discarded; quotient rounds toward zero.
- rd = 0: the operation still runs full latency. result_valid still pulses; regfile ignores writes to $0.
- Reset in any state: next cycle state=IDLE. multOngoing, md_stall, result_valid and exception = 0; inM, result and wb_rd = 0; counter = 0.
- Reset overrides a simultaneous start.
- Reset values of all outputs: 0.

Test Plan:
- Mul sign and timing: mul r5 = 7 * -6, accepted at T. Expect:
  - multOngoing=1 over T+1..T+33 with inM=dx_insn.
  - DONE at T+34: result=0xFFFFFFD6 (-42), wb_rd=5, exception=0, result_valid for 1 cycle.
  - Then IDLE with inM=0.
- Div rounding: div r3 = -17 / 5. Expect result=0xFFFFFFFD (-3), exception=0, result_valid at T+34.
- Div by zero: div r4 = 9 / 0. Expect result_valid=1, result=0, exception=1 at T+1; multOngoing never asserted.
- Mul overflow: 65536 * 65536. Expect result=0x00000000, exception=1. Also 0x7FFFFFFF * 1 -> 0x7FFFFFFF, exception=0.
- Structural and back-to-back:
  - Second mul presented at T+5: md_stall=1 from T+5 through T+33, 0 at T+34.
  - Second mul accepted on the DONE edge; its RUN starts at T+35 with inM updated.
  - A killed mul at T+5 (dx_kill=1) gives md_stall=0.
- Reset mid-op: assert reset at T+10 of a running div. Expect:
  - At T+11: state IDLE, multOngoing=0, inM=0, no result_valid pulse ever.
  - A new mul accepted at T+12 completes normally at T+46.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / divide unit sitting beside the execute stage.
// Multiply: shift-add over a 64-bit unsigned product, sign applied in FIX.
// Divide: restoring algorithm on magnitudes, quotient truncates toward zero.
module multdiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      dx_insn,
   input  logic             dx_kill,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic             multOngoing,
   output logic [31:0]      inM,
   output logic             md_stall,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic [4:0]       wb_rd,
   output logic             exception
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFix,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [31:0]        insn_q;
   logic [CntW-1:0]    cnt_q;
   logic               is_div_q;
   logic               neg_q;
   logic [WIDTH-1:0]   mag_a_q;
   logic [WIDTH-1:0]   mag_b_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quot_q;
   logic [WIDTH-1:0]   res_q;
   logic               exc_q;

   // Decode of the D/X instruction
   logic             is_mul, is_div, md_insn, start, div_zero, occupied;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign is_mul   = (dx_insn[31:27] == 5'b00000) && (dx_insn[6:2] == 5'b00110);
   assign is_div   = (dx_insn[31:27] == 5'b00000) && (dx_insn[6:2] == 5'b00111);
   assign md_insn  = is_mul | is_div;
   assign occupied = (state_q == StRun) || (state_q == StFix);
   // Kill blocks acceptance; a new op may enter from IDLE or on the DONE edge
   assign start    = md_insn & ~dx_kill & ((state_q == StIdle) || (state_q == StDone));
   assign div_zero = is_div & (operandB == '0);
   assign abs_a    = operandA[WIDTH-1] ? -operandA : operandA;
   assign abs_b    = operandB[WIDTH-1] ? -operandB : operandB;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = div_zero ? StDone : StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (cnt_q == LastCnt) begin
               state_d = StFix;
            end
         end
         StFix:   state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   // One iteration of shift-add multiply and restoring divide
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_step;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quot_step;

   always_comb begin
      mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
      prod_step = {mul_sum, prod_q[WIDTH-1:1]};
      div_shift = {rem_q, quot_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b_q};
      // Top bit of the difference is the borrow: set means restore
      if (!div_diff[WIDTH]) begin
         rem_step  = div_diff[WIDTH-1:0];
         quot_step = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_step  = div_shift[WIDTH-1:0];
         quot_step = {quot_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix-up and overflow detection for the FIX cycle
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quot_signed;
   logic               mul_ovf;
   logic               div_ovf;

   always_comb begin
      prod_signed = neg_q ? -prod_q : prod_q;
      quot_signed = neg_q ? -quot_q : quot_q;
      // Fits in WIDTH bits only if the upper WIDTH+1 bits are a sign extension
      mul_ovf = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || (~|prod_signed[2*WIDTH-1:WIDTH-1]));
      // Only -2^(W-1) / -1 yields a positive quotient with the top bit set
      div_ovf = ~neg_q & quot_q[WIDTH-1];
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clock) begin
      if (reset) begin
         insn_q   <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         res_q    <= '0;
         exc_q    <= 1'b0;
      end else if (start) begin
         insn_q   <= dx_insn;
         cnt_q    <= '0;
         is_div_q <= is_div;
         neg_q    <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
         mag_a_q  <= abs_a;
         mag_b_q  <= abs_b;
         prod_q   <= {{WIDTH{1'b0}}, abs_b};
         rem_q    <= '0;
         quot_q   <= abs_a;
         // Divide by zero skips straight to DONE with a zero result
         res_q    <= '0;
         exc_q    <= div_zero;
      end else begin
         unique case (state_q)
            StRun: begin
               cnt_q <= cnt_q + 1'b1;
               if (is_div_q) begin
                  rem_q  <= rem_step;
                  quot_q <= quot_step;
               end else begin
                  prod_q <= prod_step;
               end
            end
            StFix: begin
               if (is_div_q) begin
                  res_q <= quot_signed;
                  exc_q <= div_ovf;
               end else begin
                  res_q <= prod_signed[WIDTH-1:0];
                  exc_q <= mul_ovf;
               end
            end
            StDone: begin
               // No new op accepted, so the unit drops back to IDLE
               insn_q <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign multOngoing  = occupied;
   assign md_stall     = md_insn & ~dx_kill & occupied;
   assign inM          = insn_q;
   assign result       = res_q;
   assign result_valid = (state_q == StDone);
   assign wb_rd        = insn_q[26:22];
   assign exception    = exc_q & (state_q == StDone);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: timing, sign handling, overflow,
// structural stall, kill priority, back-to-back issue and reset.
module tb_multdiv_unit;

   logic        clock;
   logic        reset;
   logic [31:0] dx_insn;
   logic        dx_kill;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        multOngoing;
   logic [31:0] inM;
   logic        md_stall;
   logic [31:0] result;
   logic        result_valid;
   logic [4:0]  wb_rd;
   logic        exception;

   int checks;
   int errors;

   multdiv_unit #(
      .WIDTH(32)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .dx_insn     (dx_insn),
      .dx_kill     (dx_kill),
      .operandA    (operandA),
      .operandB    (operandB),
      .multOngoing (multOngoing),
      .inM         (inM),
      .md_stall    (md_stall),
      .result      (result),
      .result_valid(result_valid),
      .wb_rd       (wb_rd),
      .exception   (exception)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mk_insn(input logic [4:0] rd, input logic [4:0] alu);
      mk_insn = {5'b00000, rd, 15'b0, alu, 2'b00};
   endfunction

   localparam logic [4:0] AluMul = 5'b00110;
   localparam logic [4:0] AluDiv = 5'b00111;

   // Advance to the next cycle; outputs settle 1 time unit after the edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      dx_insn  = 32'h0;
      dx_kill  = 1'b0;
      operandA = 32'h0;
      operandB = 32'h0;
   endtask

   // Present one op in the current cycle and run until result_valid (bounded)
   task automatic do_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output logic [4:0] rd,
                        output int lat, output logic seen);
      dx_insn  = ins;
      operandA = a;
      operandB = b;
      dx_kill  = 1'b0;
      step();
      idle_inputs();
      lat  = 1;
      seen = multOngoing;
      while (!result_valid && lat < 40) begin
         step();
         lat++;
         seen = seen | multOngoing;
      end
      if (!result_valid) lat = -1;
      res = result;
      exc = exception;
      rd  = wb_rd;
      step();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      dx_insn  = mk_insn(5'd5, AluMul);
      operandA = 32'd3;
      operandB = 32'd4;
      dx_kill  = 1'b0;
      step();
      step();
      reset = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if (multOngoing !== 1'b0) begin
         errors++;
         $display("FAIL reset_ongoing: got %b expected 0", multOngoing);
      end
      checks++;
      if (inM !== 32'h0) begin
         errors++;
         $display("FAIL reset_inM: got %h expected 00000000", inM);
      end
      checks++;
      if (result_valid !== 1'b0 || result !== 32'h0 || wb_rd !== 5'd0 || exception !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b result=%h rd=%0d exc=%b expected all 0",
                  result_valid, result, wb_rd, exception);
      end
      checks++;
      if (md_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall: got %b expected 0", md_stall);
      end
   endtask

   task automatic test_mul_sign();
      logic [31:0] ins;
      int          bad;
      ins      = mk_insn(5'd5, AluMul);
      dx_insn  = ins;
      operandA = 32'd7;
      operandB = 32'hFFFF_FFFA;
      #1;
      checks++;
      if (md_stall !== 1'b0) begin
         errors++;
         $display("FAIL mul_accept_stall: got %b expected 0", md_stall);
      end
      step();
      idle_inputs();
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         checks++;
         if (multOngoing !== 1'b1 || inM !== ins || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy_T+%0d: got ongoing=%b inM=%h valid=%b expected 1 %h 0",
                     k, multOngoing, inM, result_valid, ins);
         end
         step();
      end
      checks++;
      if (result_valid !== 1'b1 || multOngoing !== 1'b0) begin
         errors++;
         $display("FAIL mul_done_T+34: got valid=%b ongoing=%b expected 1 0",
                  result_valid, multOngoing);
      end
      checks++;
      if (result !== 32'hFFFF_FFD6 || wb_rd !== 5'd5 || exception !== 1'b0) begin
         errors++;
         $display("FAIL mul_result: got %h rd=%0d exc=%b expected ffffffd6 rd=5 exc=0",
                  result, wb_rd, exception);
      end
      step();
      checks++;
      if (result_valid !== 1'b0 || inM !== 32'h0 || multOngoing !== 1'b0) begin
         errors++;
         $display("FAIL mul_back_idle: got valid=%b inM=%h ongoing=%b expected 0 0 0",
                  result_valid, inM, multOngoing);
      end
   endtask

   task automatic test_div();
      logic [31:0] res;
      logic        exc, seen;
      logic [4:0]  rd;
      int          lat;
      do_op(mk_insn(5'd3, AluDiv), 32'hFFFF_FFEF, 32'd5, res, exc, rd, lat, seen);
      checks++;
      if (lat != 34 || res !== 32'hFFFF_FFFD || exc !== 1'b0 || rd !== 5'd3) begin
         errors++;
         $display("FAIL div_round: got lat=%0d res=%h exc=%b rd=%0d expected 34 fffffffd 0 3",
                  lat, res, exc, rd);
      end
      do_op(mk_insn(5'd7, AluDiv), 32'd100, 32'hFFFF_FFF9, res, exc, rd, lat, seen);
      checks++;
      if (lat != 34 || res !== 32'hFFFF_FFF2 || exc !== 1'b0) begin
         errors++;
         $display("FAIL div_neg_divisor: got lat=%0d res=%h exc=%b expected 34 fffffff2 0",
                  lat, res, exc);
      end
      do_op(mk_insn(5'd8, AluDiv), 32'h8000_0000, 32'hFFFF_FFFF, res, exc, rd, lat, seen);
      checks++;
      if (lat != 34 || res !== 32'h8000_0000 || exc !== 1'b1) begin
         errors++;
         $display("FAIL div_overflow: got lat=%0d res=%h exc=%b expected 34 80000000 1",
                  lat, res, exc);
      end
      do_op(mk_insn(5'd4, AluDiv), 32'd9, 32'd0, res, exc, rd, lat, seen);
      checks++;
      if (lat != 1 || res !== 32'h0 || exc !== 1'b1 || rd !== 5'd4) begin
         errors++;
         $display("FAIL div_by_zero: got lat=%0d res=%h exc=%b rd=%0d expected 1 0 1 4",
                  lat, res, exc, rd);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL div_by_zero_ongoing: got %b expected 0", seen);
      end
   endtask

   task automatic test_mul_overflow();
      logic [31:0] res;
      logic        exc, seen;
      logic [4:0]  rd;
      int          lat;
      do_op(mk_insn(5'd10, AluMul), 32'd65536, 32'd65536, res, exc, rd, lat, seen);
      checks++;
      if (lat != 34 || res !== 32'h0 || exc !== 1'b1) begin
         errors++;
         $display("FAIL mul_overflow: got lat=%0d res=%h exc=%b expected 34 0 1", lat, res, exc);
      end
      do_op(mk_insn(5'd11, AluMul), 32'h7FFF_FFFF, 32'd1, res, exc, rd, lat, seen);
      checks++;
      if (res !== 32'h7FFF_FFFF || exc !== 1'b0) begin
         errors++;
         $display("FAIL mul_max_pos: got res=%h exc=%b expected 7fffffff 0", res, exc);
      end
      do_op(mk_insn(5'd12, AluMul), 32'hFFFF_0000, 32'd32768, res, exc, rd, lat, seen);
      checks++;
      if (res !== 32'h8000_0000 || exc !== 1'b0) begin
         errors++;
         $display("FAIL mul_min_neg: got res=%h exc=%b expected 80000000 0", res, exc);
      end
      do_op(mk_insn(5'd0, AluMul), 32'd2, 32'd3, res, exc, rd, lat, seen);
      checks++;
      if (lat != 34 || res !== 32'd6 || rd !== 5'd0) begin
         errors++;
         $display("FAIL mul_rd_zero: got lat=%0d res=%h rd=%0d expected 34 6 0", lat, res, rd);
      end
      // Non mul/div ALU op must not start the unit
      dx_insn  = mk_insn(5'd5, 5'b00000);
      operandA = 32'd1;
      operandB = 32'd1;
      step();
      idle_inputs();
      checks++;
      if (multOngoing !== 1'b0 || inM !== 32'h0) begin
         errors++;
         $display("FAIL other_op_ignored: got ongoing=%b inM=%h expected 0 0", multOngoing, inM);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins_a, ins_b;
      ins_a    = mk_insn(5'd5, AluMul);
      ins_b    = mk_insn(5'd9, AluMul);
      dx_insn  = ins_a;
      operandA = 32'd7;
      operandB = 32'hFFFF_FFFA;
      step();
      idle_inputs();
      for (int k = 1; k < 5; k++) step();
      // T+5: second mul waits in D/X
      dx_insn  = ins_b;
      operandA = 32'd3;
      operandB = 32'd4;
      for (int k = 5; k <= 33; k++) begin
         #1;
         checks++;
         if (md_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall_T+%0d: got %b expected 1", k, md_stall);
         end
         step();
      end
      #1;
      checks++;
      if (md_stall !== 1'b0 || result_valid !== 1'b1 || result !== 32'hFFFF_FFD6) begin
         errors++;
         $display("FAIL b2b_done_T+34: got stall=%b valid=%b res=%h expected 0 1 ffffffd6",
                  md_stall, result_valid, result);
      end
      step();
      idle_inputs();
      checks++;
      if (inM !== ins_b || multOngoing !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_run: got inM=%h ongoing=%b expected %h 1",
                  inM, multOngoing, ins_b);
      end
      for (int k = 35; k < 68; k++) step();
      checks++;
      if (result_valid !== 1'b1 || result !== 32'd12 || wb_rd !== 5'd9) begin
         errors++;
         $display("FAIL b2b_second_result: got valid=%b res=%h rd=%0d expected 1 0000000c 9",
                  result_valid, result, wb_rd);
      end
      step();
   endtask

   task automatic test_kill();
      dx_insn  = mk_insn(5'd5, AluMul);
      operandA = 32'd2;
      operandB = 32'd2;
      step();
      idle_inputs();
      for (int k = 1; k < 5; k++) step();
      dx_insn  = mk_insn(5'd6, AluMul);
      operandA = 32'd9;
      operandB = 32'd9;
      dx_kill  = 1'b1;
      #1;
      checks++;
      if (md_stall !== 1'b0) begin
         errors++;
         $display("FAIL kill_no_stall: got %b expected 0", md_stall);
      end
      // Keep the killed op present through DONE; it must never be accepted
      for (int k = 5; k <= 34; k++) step();
      idle_inputs();
      checks++;
      if (multOngoing !== 1'b0 || inM !== 32'h0) begin
         errors++;
         $display("FAIL kill_not_latched: got ongoing=%b inM=%h expected 0 0", multOngoing, inM);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      logic        exc, seen;
      logic [4:0]  rd;
      int          lat;
      int          pulses;
      pulses   = 0;
      dx_insn  = mk_insn(5'd3, AluDiv);
      operandA = 32'hFFFF_FFEF;
      operandB = 32'd5;
      step();
      idle_inputs();
      for (int k = 1; k < 10; k++) begin
         if (result_valid) pulses++;
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (multOngoing !== 1'b0 || inM !== 32'h0 || result_valid !== 1'b0 || result !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_T+11: got ongoing=%b inM=%h valid=%b res=%h expected 0 0 0 0",
                  multOngoing, inM, result_valid, result);
      end
      if (result_valid) pulses++;
      step();
      if (result_valid) pulses++;
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", pulses);
      end
      do_op(mk_insn(5'd6, AluMul), 32'd5, 32'd5, res, exc, rd, lat, seen);
      checks++;
      if (lat != 34 || res !== 32'd25 || rd !== 5'd6 || exc !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_new_mul: got lat=%0d res=%h rd=%0d exc=%b expected 34 19 6 0",
                  lat, res, rd, exc);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle_inputs();
      test_reset();
      test_mul_sign();
      test_div();
      test_mul_overflow();
      test_back_to_back();
      test_kill();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
